// File: rtl/grf_wbq_pkg.sv
// Shared types and sizing for the GRF write-back queue.
package grf_wbq_pkg;

    localparam int unsigned WBQ_DEPTH = 4;
    localparam int unsigned WBQ_PTR_W = 2;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    // "reg" is a keyword, so the destination field is named wreg.
    typedef struct packed {
        logic [4:0]  wreg;
        logic [31:0] data;
        logic [31:0] pc;
    } wb_entry_t;

endpackage

// File: rtl/grf_wbq_if.sv
// Producer, GRF write-port and hazard-query signals of the write-back queue.
interface grf_wbq_if import grf_wbq_pkg::*; #(
    parameter int unsigned PTR_W = WBQ_PTR_W
);
    logic             a_valid;
    logic             a_ready;
    logic [4:0]       a_reg;
    logic [31:0]      a_data;
    logic [31:0]      a_pc;
    logic             b_valid;
    logic             b_ready;
    logic [4:0]       b_reg;
    logic [31:0]      b_data;
    logic [31:0]      b_pc;
    logic             grf_we;
    logic [4:0]       grf_reg;
    logic [31:0]      grf_data;
    logic [31:0]      grf_pc;
    logic [4:0]       query_reg1;
    logic [4:0]       query_reg2;
    logic             query_busy1;
    logic             query_busy2;
    logic [PTR_W:0]   count;

    modport master (
        output a_valid, a_reg, a_data, a_pc,
        output b_valid, b_reg, b_data, b_pc,
        output query_reg1, query_reg2,
        input  a_ready, b_ready,
        input  grf_we, grf_reg, grf_data, grf_pc,
        input  query_busy1, query_busy2, count
    );

    modport slave (
        input  a_valid, a_reg, a_data, a_pc,
        input  b_valid, b_reg, b_data, b_pc,
        input  query_reg1, query_reg2,
        output a_ready, b_ready,
        output grf_we, grf_reg, grf_data, grf_pc,
        output query_busy1, query_busy2, count
    );
endinterface

// File: rtl/grf_wbq_storage.sv
// Entry array with two adjacent write ports, head read and a valid-but-not-head mask.
module grf_wbq_storage import grf_wbq_pkg::*; #(
    parameter int unsigned DEPTH = WBQ_DEPTH,
    parameter int unsigned PTR_W = WBQ_PTR_W
) (
    input  logic                   clk,
    input  logic                   i_we0,
    input  logic [PTR_W-1:0]       i_addr0,
    input  wb_entry_t              i_ent0,
    input  logic                   i_we1,
    input  wb_entry_t              i_ent1,
    input  logic [PTR_W-1:0]       i_head,
    input  logic [PTR_W:0]         i_count,
    output wb_entry_t              o_head,
    output logic [DEPTH-1:0]       o_busy_mask,
    output logic [DEPTH-1:0][4:0]  o_regs
);
    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] w_addr1;

    assign w_addr1 = i_addr0 + PTR_W'(1);

    // Port 1 always targets the slot after port 0, so the two never collide.
    always_ff @(posedge clk) begin
        if (i_we0) r_mem[i_addr0] <= i_ent0;
        if (i_we1) r_mem[w_addr1] <= i_ent1;
    end

    assign o_head = r_mem[i_head];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        logic [PTR_W-1:0] w_off;
        assign w_off           = PTR_W'(gi) - i_head;
        assign o_busy_mask[gi] = (w_off != '0) && ({1'b0, w_off} < i_count);
        assign o_regs[gi]      = r_mem[gi].wreg;
    end

endmodule

// File: rtl/grf_wb_queue.sv
// Merges pipeline and mult/div write-backs into the single GRF write port,
// draining one entry per cycle and flagging registers with writes still queued.
module grf_wb_queue import grf_wbq_pkg::*; #(
    parameter int unsigned DEPTH = WBQ_DEPTH,
    parameter int unsigned PTR_W = WBQ_PTR_W
) (
    input  logic         clk,
    input  logic         reset,
    grf_wbq_if.slave     bus
);
    localparam int unsigned CW = PTR_W + 1;
    localparam int unsigned FW = PTR_W + 2;

    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CW-1:0]         r_count;

    logic                  w_nonempty;
    logic [FW-1:0]         w_free;
    logic                  w_need_a;
    logic                  w_push_a;
    logic                  w_push_b;
    wb_entry_t             w_ent_a;
    wb_entry_t             w_ent_b;
    wb_entry_t             w_head;
    logic [DEPTH-1:0]      w_mask;
    logic [DEPTH-1:0][4:0] w_regs;
    logic                  w_hit1;
    logic                  w_hit2;

    assign w_nonempty = (r_count != '0);
    // The head leaves at every nonempty edge, so its slot counts as free.
    assign w_free     = FW'(DEPTH) - FW'(r_count) + FW'(w_nonempty);
    assign w_need_a   = bus.a_valid && (bus.a_reg != REG_ZERO);

    assign bus.a_ready = (w_free >= FW'(1));
    assign bus.b_ready = (w_free >= (FW'(1) + FW'(w_need_a)));

    assign w_push_a = bus.a_valid && bus.a_ready && (bus.a_reg != REG_ZERO);
    assign w_push_b = bus.b_valid && bus.b_ready && (bus.b_reg != REG_ZERO);

    assign w_ent_a = '{wreg: bus.a_reg, data: bus.a_data, pc: bus.a_pc};
    assign w_ent_b = '{wreg: bus.b_reg, data: bus.b_data, pc: bus.b_pc};

    grf_wbq_storage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_storage (
        .clk         (clk),
        .i_we0       (w_push_a || w_push_b),
        .i_addr0     (r_tail),
        .i_ent0      (w_push_a ? w_ent_a : w_ent_b),
        .i_we1       (w_push_a && w_push_b),
        .i_ent1      (w_ent_b),
        .i_head      (r_head),
        .i_count     (r_count),
        .o_head      (w_head),
        .o_busy_mask (w_mask),
        .o_regs      (w_regs)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_nonempty);
            r_tail  <= r_tail + PTR_W'(w_push_a) + PTR_W'(w_push_b);
            r_count <= r_count - CW'(w_nonempty) + CW'(w_push_a) + CW'(w_push_b);
        end
    end

    assign bus.grf_we   = w_nonempty;
    assign bus.grf_reg  = w_nonempty ? w_head.wreg : '0;
    assign bus.grf_data = w_nonempty ? w_head.data : '0;
    assign bus.grf_pc   = w_nonempty ? w_head.pc   : '0;
    assign bus.count    = r_count;

    // Head is excluded: the GRF forwards its same-cycle write to readers.
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_mask[i] && (w_regs[i] == bus.query_reg1)) w_hit1 = 1'b1;
            if (w_mask[i] && (w_regs[i] == bus.query_reg2)) w_hit2 = 1'b1;
        end
    end

    assign bus.query_busy1 = (bus.query_reg1 != REG_ZERO) && w_hit1;
    assign bus.query_busy2 = (bus.query_reg2 != REG_ZERO) && w_hit2;

endmodule

// File: tb/tb_grf_wb_queue.sv
// Directed stimulus with a write-order scoreboard for grf_wb_queue.
module tb_grf_wb_queue;
    import grf_wbq_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    wb_entry_t sb[$];

    grf_wbq_if #(.PTR_W(2)) bus ();

    grf_wb_queue #(.DEPTH(4), .PTR_W(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [4:0] r, input logic [31:0] d, input logic [31:0] p);
        bus.a_valid = v; bus.a_reg = r; bus.a_data = d; bus.a_pc = p;
    endtask

    task automatic set_b(input logic v, input logic [4:0] r, input logic [31:0] d, input logic [31:0] p);
        bus.b_valid = v; bus.b_reg = r; bus.b_data = d; bus.b_pc = p;
    endtask

    task automatic idle();
        set_a(1'b0, 5'd0, 32'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d, input logic [31:0] p);
        sb.push_back('{wreg: r, data: d, pc: p});
    endtask

    // Monitor: every GRF write must match the oldest expected write.
    always @(negedge clk) begin
        wb_entry_t e;
        if (bus.grf_we) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL grf_unexpected: got write reg %0d data %0h, expected no write",
                         bus.grf_reg, bus.grf_data);
            end else begin
                e = sb.pop_front();
                chk("grf_reg",  32'(bus.grf_reg), 32'(e.wreg));
                chk("grf_data", bus.grf_data,     e.data);
                chk("grf_pc",   bus.grf_pc,       e.pc);
            end
        end else begin
            chk("grf_idle_zero", 32'(bus.grf_reg) | bus.grf_data | bus.grf_pc, 32'd0);
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        bus.query_reg1 = 5'd5;
        bus.query_reg2 = 5'd5;
        repeat (2) cyc();

        @(negedge clk);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_we",    32'(bus.grf_we), 32'd0);
        chk("rst_busy1", 32'(bus.query_busy1), 32'd0);
        chk("rst_busy2", 32'(bus.query_busy2), 32'd0);
        cyc();
        reset = 1'b0;

        // Single A write: visible the next cycle, gone the cycle after
        set_a(1'b1, 5'd5, 32'h1234, 32'h3000);
        @(negedge clk);
        chk("t1_a_ready", 32'(bus.a_ready), 32'd1);
        expect_wr(5'd5, 32'h1234, 32'h3000);
        cyc();
        idle();
        @(negedge clk);
        chk("t1_we",    32'(bus.grf_we), 32'd1);
        chk("t1_count", 32'(bus.count),  32'd1);
        cyc();
        @(negedge clk);
        chk("t1_we_after",    32'(bus.grf_we), 32'd0);
        chk("t1_count_after", 32'(bus.count),  32'd0);

        // Same-cycle A and B on an empty queue
        cyc();
        set_a(1'b1, 5'd3, 32'd1, 32'h100);
        set_b(1'b1, 5'd4, 32'd2, 32'h104);
        @(negedge clk);
        chk("t2_a_ready", 32'(bus.a_ready), 32'd1);
        chk("t2_b_ready", 32'(bus.b_ready), 32'd1);
        expect_wr(5'd3, 32'd1, 32'h100);
        expect_wr(5'd4, 32'd2, 32'h104);
        cyc();
        idle();
        @(negedge clk);
        chk("t2_count2", 32'(bus.count), 32'd2);
        cyc();
        @(negedge clk);
        chk("t2_count1", 32'(bus.count), 32'd1);
        cyc();
        @(negedge clk);
        chk("t2_count0", 32'(bus.count), 32'd0);

        // Fill with paired writes, then one free slot: A wins, B stalls a cycle
        for (int k = 0; k < 3; k++) begin
            cyc();
            set_a(1'b1, 5'(7 + 2 * k), 32'(32'h70 + 2 * k), 32'(32'h700 + 8 * k));
            set_b(1'b1, 5'(8 + 2 * k), 32'(32'h71 + 2 * k), 32'(32'h704 + 8 * k));
            @(negedge clk);
            chk("t3_fill_a_ready", 32'(bus.a_ready), 32'd1);
            chk("t3_fill_b_ready", 32'(bus.b_ready), 32'd1);
            expect_wr(5'(7 + 2 * k), 32'(32'h70 + 2 * k), 32'(32'h700 + 8 * k));
            expect_wr(5'(8 + 2 * k), 32'(32'h71 + 2 * k), 32'(32'h704 + 8 * k));
        end
        cyc();
        set_a(1'b1, 5'd13, 32'h76, 32'h718);
        set_b(1'b1, 5'd14, 32'h77, 32'h71c);
        @(negedge clk);
        chk("t3_full_count",   32'(bus.count),   32'd4);
        chk("t3_full_a_ready", 32'(bus.a_ready), 32'd1);
        chk("t3_full_b_stall", 32'(bus.b_ready), 32'd0);
        expect_wr(5'd13, 32'h76, 32'h718);
        cyc();
        set_a(1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t3_full_count2", 32'(bus.count),   32'd4);
        chk("t3_b_ready_now", 32'(bus.b_ready), 32'd1);
        expect_wr(5'd14, 32'h77, 32'h71c);
        cyc();
        idle();
        repeat (4) cyc();
        @(negedge clk);
        chk("t3_drained", 32'(bus.count), 32'd0);

        // Register 0 is accepted but never written
        cyc();
        set_a(1'b1, 5'd0, 32'hdead, 32'h4000);
        @(negedge clk);
        chk("t4_a_ready", 32'(bus.a_ready), 32'd1);
        cyc();
        idle();
        @(negedge clk);
        chk("t4_count", 32'(bus.count),  32'd0);
        chk("t4_we",    32'(bus.grf_we), 32'd0);

        // Hazard query: head reg 8 excluded, reg 9 behind it is busy
        cyc();
        set_a(1'b1, 5'd8, 32'h88, 32'h500);
        set_b(1'b1, 5'd9, 32'h99, 32'h504);
        @(negedge clk);
        expect_wr(5'd8, 32'h88, 32'h500);
        expect_wr(5'd9, 32'h99, 32'h504);
        cyc();
        idle();
        bus.query_reg1 = 5'd9;
        bus.query_reg2 = 5'd8;
        #1;
        chk("t5_busy_reg9", 32'(bus.query_busy1), 32'd1);
        chk("t5_busy_head", 32'(bus.query_busy2), 32'd0);
        bus.query_reg1 = 5'd0;
        bus.query_reg2 = 5'd9;
        #1;
        chk("t5_busy_reg0",  32'(bus.query_busy1), 32'd0);
        chk("t5_busy_reg9b", 32'(bus.query_busy2), 32'd1);
        cyc();
        chk("t5_busy_9_head", 32'(bus.query_busy2), 32'd0);
        cyc();
        @(negedge clk);
        chk("t5_count0", 32'(bus.count), 32'd0);

        // Asynchronous reset with three entries queued
        cyc();
        set_a(1'b1, 5'd20, 32'h200, 32'h600);
        set_b(1'b1, 5'd21, 32'h210, 32'h604);
        @(negedge clk);
        expect_wr(5'd20, 32'h200, 32'h600);
        expect_wr(5'd21, 32'h210, 32'h604);
        cyc();
        set_a(1'b1, 5'd22, 32'h220, 32'h608);
        set_b(1'b1, 5'd23, 32'h230, 32'h60c);
        @(negedge clk);
        chk("t6_a_ready", 32'(bus.a_ready), 32'd1);
        chk("t6_b_ready", 32'(bus.b_ready), 32'd1);
        expect_wr(5'd22, 32'h220, 32'h608);
        expect_wr(5'd23, 32'h230, 32'h60c);
        cyc();
        idle();
        chk("t6_pre_count", 32'(bus.count), 32'd3);
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("t6_rst_we",    32'(bus.grf_we), 32'd0);
        chk("t6_rst_count", 32'(bus.count),  32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        chk("t6_post_count", 32'(bus.count), 32'd0);
        cyc();
        set_a(1'b1, 5'd30, 32'h300, 32'h700);
        @(negedge clk);
        expect_wr(5'd30, 32'h300, 32'h700);
        cyc();
        idle();
        @(negedge clk);
        chk("t6_new_count", 32'(bus.count), 32'd1);
        cyc();
        @(negedge clk);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
